// File: rtl/tr_pcm_player_pkg.sv
// tr_pcm_player shared types and constants.
// Optional build macro: TR_PCM_PLAYER_MUTE_ON_UNDERRUN_EN.
package tr_pcm_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_t;

  localparam logic       ADR_A4      = 1'b0;
  localparam logic       ADR_A5      = 1'b1;
  localparam logic [7:0] PCM_SILENCE = 8'h80;

endpackage

// File: rtl/tr_pcm_player_if.sv
// tr_pcm responder bus: req/ack write handshake plus data lanes.
// master = player side, slave = tr_pcm side.
interface tr_pcm_player_if;
  import tr_pcm_player_pkg::*;

  logic       req;
  logic       ack;
  logic       wrt;
  logic       adr;
  logic [7:0] dbo;
  logic [7:0] dbi;

  modport master (
    output req,
    output wrt,
    output adr,
    output dbo,
    input  ack,
    input  dbi
  );

  modport slave (
    input  req,
    input  wrt,
    input  adr,
    input  dbo,
    output ack,
    output dbi
  );

endinterface

// File: rtl/tr_pcm_player_fifo.sv
// pcm_sample_fifo: 8-bit sample FIFO, depth 2**FIFO_AW.
// Read data is the current head, valid whenever empty is low.
module pcm_sample_fifo
  import tr_pcm_player_pkg::*;
#(
  parameter int FIFO_AW = 3
) (
  input  logic             clk21m,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic [FIFO_AW:0] level,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wp;
  logic [FIFO_AW-1:0] rp;
  logic               do_push;
  logic               do_pop;

  assign full    = (level == (FIFO_AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  // a pop frees the head slot, so a full FIFO may take a push
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push)
        wp <= wp + 1'b1;
      if (do_pop)
        rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk21m) begin
    if (do_push)
      mem[wp] <= din;
  end

endmodule

// File: rtl/tr_pcm_player.sv
// tr_pcm_player: paces buffered PCM samples onto tr_pcm A4h, cfg to A5h.
// Macro TR_PCM_PLAYER_MUTE_ON_UNDERRUN_EN: write 80h on underrun ticks.
module tr_pcm_player
  import tr_pcm_player_pkg::*;
#(
  parameter int FIFO_AW     = 3,
  parameter int PERIOD      = 1368,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk21m,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             cfg_req,
  input  logic [7:0]       cfg_data,
  output logic             cfg_busy,
  tr_pcm_player_if.master  bus,
  output logic [FIFO_AW:0] fifo_level,
  output logic             underrun,
  output logic             bus_err,
  input  logic             status_clr
);

  localparam int CW = $clog2(PERIOD);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_t        state;
  logic [CW-1:0] count;
  logic [TW-1:0] wcnt;
  logic          tick;
  logic          tick_pend;
  logic          cfg_pend;
  logic [7:0]    cfg_reg;
  logic          cur_cfg;
  logic          full;
  logic          empty;
  logic          push;
  logic [7:0]    fifo_dout;
  logic          start_cfg;
  logic          start_smp;
  logic          udr_hit;
  logic          wait_to;
  logic          unused_dbi;

  assign unused_dbi = ^bus.dbi;

  assign s_ready = reset_n & ~full;
  assign push    = s_valid & s_ready;
  assign tick    = enable
                 & (count == CW'(PERIOD - 1));

  // cfg wins; sample work needs enable so a
  // falling enable starts nothing new
  assign start_cfg = (state == ST_IDLE)
                   & cfg_pend;
  assign start_smp = (state == ST_IDLE)
                   & ~cfg_pend & enable
                   & tick_pend & ~empty;
  assign udr_hit   = (state == ST_IDLE)
                   & ~cfg_pend & enable
                   & tick_pend & empty;
  assign wait_to   = (state == ST_WAIT)
                   & ~bus.ack
                   & (wcnt == TW'(ACK_TIMEOUT - 1));

  assign cfg_busy = cfg_pend
                  | (cur_cfg & (state != ST_IDLE));

  pcm_sample_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk21m  (clk21m),
    .reset_n (reset_n),
    .push    (push),
    .pop     (start_smp),
    .din     (s_data),
    .dout    (fifo_dout),
    .level   (fifo_level),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      tick_pend <= 1'b0;
      cfg_pend  <= 1'b0;
      cfg_reg   <= '0;
      underrun  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if (!enable || tick)
        count <= '0;
      else
        count <= count + 1'b1;

      if (!enable)
        tick_pend <= 1'b0;
      else if (tick)
        tick_pend <= 1'b1;
      else if (start_smp || udr_hit)
        tick_pend <= 1'b0;

      if (cfg_req) begin
        cfg_pend <= 1'b1;
        cfg_reg  <= cfg_data;
      end else if (start_cfg) begin
        cfg_pend <= 1'b0;
      end

      if (status_clr) begin
        underrun <= 1'b0;
        bus_err  <= 1'b0;
      end else begin
        if (udr_hit)
          underrun <= 1'b1;
        if (wait_to)
          bus_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      bus.req <= 1'b0;
      bus.wrt <= 1'b0;
      bus.adr <= ADR_A4;
      bus.dbo <= '0;
      cur_cfg <= 1'b0;
      wcnt    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          bus.req <= 1'b0;
          bus.wrt <= 1'b0;
          bus.adr <= ADR_A4;
          bus.dbo <= '0;
          unique case (1'b1)
            start_cfg: begin
              state   <= ST_REQ;
              bus.req <= 1'b1;
              bus.wrt <= 1'b1;
              bus.adr <= ADR_A5;
              bus.dbo <= cfg_reg;
              cur_cfg <= 1'b1;
            end
            start_smp: begin
              state   <= ST_REQ;
              bus.req <= 1'b1;
              bus.wrt <= 1'b1;
              bus.adr <= ADR_A4;
              bus.dbo <= fifo_dout;
              cur_cfg <= 1'b0;
            end
`ifdef TR_PCM_PLAYER_MUTE_ON_UNDERRUN_EN
            udr_hit: begin
              state   <= ST_REQ;
              bus.req <= 1'b1;
              bus.wrt <= 1'b1;
              bus.adr <= ADR_A4;
              bus.dbo <= PCM_SILENCE;
              cur_cfg <= 1'b0;
            end
`endif
            default: ;
          endcase
        end
        ST_REQ: begin
          bus.req <= 1'b0;
          bus.wrt <= 1'b0;
          wcnt    <= '0;
          if (bus.ack) begin
            state   <= ST_IDLE;
            bus.adr <= ADR_A4;
            bus.dbo <= '0;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // timeout drops the cycle; sample is lost
          if (bus.ack || wait_to) begin
            state   <= ST_IDLE;
            bus.adr <= ADR_A4;
            bus.dbo <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tr_pcm_player.sv
// Self-checking bench for tr_pcm_player against a sample-queue model.
// Honours TR_PCM_PLAYER_MUTE_ON_UNDERRUN_EN when built with it.
module tb_tr_pcm_player;
  import tr_pcm_player_pkg::*;

  localparam int AW  = 3;
  localparam int PER = 1368;
  localparam int TO  = 15;

  typedef struct {
    logic       adr;
    logic [7:0] d;
    int         t;
  } wr_t;

  logic          clk21m = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = '0;
  logic          cfg_req = 1'b0;
  logic [7:0]    cfg_data = '0;
  logic          status_clr = 1'b0;
  logic          s_ready;
  logic          cfg_busy;
  logic [AW:0]   fifo_level;
  logic          underrun;
  logic          bus_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ack_mode = 0;
  logic [7:0] mq[$];
  wr_t obs[$];
  wr_t ex[$];

  tr_pcm_player_if bus();

  assign bus.ack = (ack_mode == 0) ? bus.req : 1'b0;
  assign bus.dbi = 8'h00;

  tr_pcm_player #(
    .FIFO_AW     (AW),
    .PERIOD      (PER),
    .ACK_TIMEOUT (TO)
  ) dut (
    .clk21m     (clk21m),
    .reset_n    (reset_n),
    .enable     (enable),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .cfg_req    (cfg_req),
    .cfg_data   (cfg_data),
    .cfg_busy   (cfg_busy),
    .bus        (bus),
    .fifo_level (fifo_level),
    .underrun   (underrun),
    .bus_err    (bus_err),
    .status_clr (status_clr)
  );

  always #23 clk21m = ~clk21m;

  always @(posedge clk21m) cyc <= cyc + 1;

  always @(negedge clk21m) begin
    if (reset_n && bus.req) begin
      obs.push_back('{bus.adr, bus.dbo, cyc});
      n_cmp++;
      if (bus.wrt !== 1'b1) begin
        n_bad++;
        $display("FAIL wrt_in_req got %b want 1", bus.wrt);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk21m);
  endtask

  task automatic do_reset();
    @(negedge clk21m);
    reset_n = 1'b0;
    enable = 1'b0;
    s_valid = 1'b0;
    cfg_req = 1'b0;
    status_clr = 1'b0;
    ack_mode = 0;
    repeat (2) @(negedge clk21m);
    reset_n = 1'b1;
    @(negedge clk21m);
    obs.delete();
    ex.delete();
    mq.delete();
  endtask

  task automatic push_val(input logic [7:0] d);
    s_valid = 1'b1;
    s_data = d;
    if (mq.size() < 8) mq.push_back(d);
    @(negedge clk21m);
    s_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    status_clr = 1'b1;
    @(negedge clk21m);
    status_clr = 1'b0;
    @(negedge clk21m);
  endtask

  task automatic test_reset();
    @(negedge clk21m);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.req, bus.wrt, bus.adr, bus.dbo} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_bus got %h want 0",
               {bus.req, bus.wrt, bus.adr, bus.dbo});
    end
    n_cmp++;
    if ({fifo_level, underrun, bus_err, cfg_busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_status got %h want 0",
               {fifo_level, underrun, bus_err, cfg_busy});
    end
    @(negedge clk21m);
    reset_n = 1'b1;
    @(negedge clk21m);
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_s_ready got %b want 1", s_ready);
    end
  endtask

  task automatic test_stream();
    int t0;
    int k;
    do_reset();
    push_val(8'd100);
    push_val(8'd200);
    k = $urandom_range(0, 3);
    for (int i = 0; i < k; i++) push_val(8'($urandom));
    k = mq.size();
    for (int i = 0; i < k; i++)
      ex.push_back('{ADR_A4, mq[i], 0});
`ifdef TR_PCM_PLAYER_MUTE_ON_UNDERRUN_EN
    ex.push_back('{ADR_A4, PCM_SILENCE, 0});
`endif
    enable = 1'b1;
    t0 = cyc;
    foreach (ex[i]) ex[i].t = t0 + (i + 1) * PER + 1;
    wait_until(t0 + k * PER + 3);
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL stream_no_underrun got %b want 0", underrun);
    end
    wait_until(t0 + (k + 1) * PER + 4);
    n_cmp++;
    if (obs.size() !== ex.size()) begin
      n_bad++;
      $display("FAIL stream_count got %0d want %0d",
               obs.size(), ex.size());
    end
    for (int i = 0; i < ex.size() && i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i] != ex[i]) begin
        n_bad++;
        $display("FAIL stream_wr%0d got %b/%h@%0d want %b/%h@%0d", i,
                 obs[i].adr, obs[i].d, obs[i].t,
                 ex[i].adr, ex[i].d, ex[i].t);
      end
    end
    n_cmp++;
    if (obs.size() >= 2 && obs[1].t - obs[0].t !== PER) begin
      n_bad++;
      $display("FAIL stream_spacing got %0d want %0d",
               obs[1].t - obs[0].t, PER);
    end
    n_cmp++;
    if (underrun !== 1'b1) begin
      n_bad++;
      $display("FAIL stream_underrun got %b want 1", underrun);
    end
    pulse_clr();
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL stream_clr got %b want 0", underrun);
    end
  endtask

  task automatic test_cfg();
    int t0;
    int c;
    logic [7:0] cv;
    do_reset();
    push_val(8'h55);
    enable = 1'b1;
    t0 = cyc;
    wait_until(t0 + PER - 1);
    cfg_req = 1'b1;
    cfg_data = 8'h03;
    @(negedge clk21m);
    cfg_req = 1'b0;
    n_cmp++;
    if (cfg_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL cfg_busy_set got %b want 1", cfg_busy);
    end
    wait_until(t0 + PER + 2);
    n_cmp++;
    if (cfg_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL cfg_busy_drop got %b want 0", cfg_busy);
    end
    wait_until(t0 + PER + 8);
    n_cmp++;
    if (obs.size() !== 2) begin
      n_bad++;
      $display("FAIL cfg_count got %0d want 2", obs.size());
    end else begin
      n_cmp++;
      if (obs[0] != '{ADR_A5, 8'h03, t0 + PER + 1}) begin
        n_bad++;
        $display("FAIL cfg_first got %b/%h@%0d want 1/03@%0d",
                 obs[0].adr, obs[0].d, obs[0].t, t0 + PER + 1);
      end
      n_cmp++;
      if (obs[1].adr !== ADR_A4 || obs[1].d !== 8'h55
          || obs[1].t <= obs[0].t) begin
        n_bad++;
        $display("FAIL cfg_second got %b/%h@%0d want 0/55 after %0d",
                 obs[1].adr, obs[1].d, obs[1].t, obs[0].t);
      end
    end
    enable = 1'b0;
    obs.delete();
    cv = 8'($urandom);
    cfg_req = 1'b1;
    cfg_data = cv;
    c = cyc;
    @(negedge clk21m);
    cfg_req = 1'b0;
    wait_until(c + 4);
    n_cmp++;
    if (obs.size() !== 1 || obs[0] != '{ADR_A5, cv, c + 2}) begin
      n_bad++;
      $display("FAIL cfg_disabled got n=%0d want 1/%h@%0d",
               obs.size(), cv, c + 2);
    end
  endtask

  task automatic test_underrun();
    int t0;
    int nw;
    do_reset();
    enable = 1'b1;
    t0 = cyc;
    wait_until(t0 + PER + 4);
    n_cmp++;
    if (underrun !== 1'b1) begin
      n_bad++;
      $display("FAIL udr_set got %b want 1", underrun);
    end
    status_clr = 1'b1;
    @(negedge clk21m);
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL udr_clr got %b want 0", underrun);
    end
    wait_until(t0 + 2 * PER + 4);
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL udr_clr_priority got %b want 0", underrun);
    end
    status_clr = 1'b0;
`ifdef TR_PCM_PLAYER_MUTE_ON_UNDERRUN_EN
    nw = 2;
`else
    nw = 0;
`endif
    n_cmp++;
    if (obs.size() !== nw) begin
      n_bad++;
      $display("FAIL udr_writes got %0d want %0d", obs.size(), nw);
    end
    for (int i = 0; i < nw && i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i] != '{ADR_A4, PCM_SILENCE, t0 + (i + 1) * PER + 1}) begin
        n_bad++;
        $display("FAIL udr_mute%0d got %b/%h@%0d want 0/80@%0d", i,
                 obs[i].adr, obs[i].d, obs[i].t, t0 + (i + 1) * PER + 1);
      end
    end
  endtask

  task automatic test_timeout();
    int t0;
    int c;
    do_reset();
    push_val(8'($urandom));
    push_val(8'($urandom));
    ack_mode = 1;
    enable = 1'b1;
    t0 = cyc;
    c = t0 + PER + 1;
    wait_until(c + 1);
    n_cmp++;
    if (obs.size() !== 1 || obs[0] != '{ADR_A4, mq[0], c}) begin
      n_bad++;
      $display("FAIL to_req got n=%0d want 1 write of %h@%0d",
               obs.size(), mq[0], c);
    end
    n_cmp++;
    if (bus.req !== 1'b0 || bus.dbo !== mq[0]) begin
      n_bad++;
      $display("FAIL to_wait got req=%b dbo=%h want 0/%h",
               bus.req, bus.dbo, mq[0]);
    end
    wait_until(c + TO);
    n_cmp++;
    if (bus_err !== 1'b0) begin
      n_bad++;
      $display("FAIL to_early got %b want 0", bus_err);
    end
    wait_until(c + TO + 1);
    n_cmp++;
    if (bus_err !== 1'b1 || bus.dbo !== 8'h00) begin
      n_bad++;
      $display("FAIL to_err got err=%b dbo=%h want 1/00",
               bus_err, bus.dbo);
    end
    ack_mode = 0;
    wait_until(t0 + 2 * PER + 3);
    n_cmp++;
    if (obs.size() !== 2 || obs[1] != '{ADR_A4, mq[1], t0 + 2 * PER + 1})
    begin
      n_bad++;
      $display("FAIL to_next got n=%0d want 2nd write %h@%0d",
               obs.size(), mq[1], t0 + 2 * PER + 1);
    end
    n_cmp++;
    if (bus_err !== 1'b1) begin
      n_bad++;
      $display("FAIL to_sticky got %b want 1", bus_err);
    end
    pulse_clr();
    n_cmp++;
    if (bus_err !== 1'b0) begin
      n_bad++;
      $display("FAIL to_clr got %b want 0", bus_err);
    end
  endtask

  task automatic test_fill();
    int t0;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      d = 8'($urandom);
      n_cmp++;
      if (s_ready !== (mq.size() < 8)) begin
        n_bad++;
        $display("FAIL fill_ready%0d got %b want %b", i,
                 s_ready, mq.size() < 8);
      end
      push_val(d);
    end
    n_cmp++;
    if (fifo_level !== 4'd8 || s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_full got lvl=%0d rdy=%b want 8/0",
               fifo_level, s_ready);
    end
    enable = 1'b1;
    t0 = cyc;
    wait_until(t0 + PER + 1);
    n_cmp++;
    if (fifo_level !== 4'd7 || s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_pop got lvl=%0d rdy=%b want 7/1",
               fifo_level, s_ready);
    end
    wait_until(t0 + 8 * PER + 3);
    n_cmp++;
    if (obs.size() !== 8 || fifo_level !== 4'd0) begin
      n_bad++;
      $display("FAIL fill_drain got n=%0d lvl=%0d want 8/0",
               obs.size(), fifo_level);
    end
    for (int i = 0; i < 8 && i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i] != '{ADR_A4, mq[i], t0 + (i + 1) * PER + 1}) begin
        n_bad++;
        $display("FAIL fill_wr%0d got %h@%0d want %h@%0d", i,
                 obs[i].d, obs[i].t, mq[i], t0 + (i + 1) * PER + 1);
      end
    end
  endtask

  task automatic test_mid_reset();
    int t0;
    do_reset();
    push_val(8'($urandom) | 8'h01);
    push_val(8'($urandom) | 8'h01);
    ack_mode = 1;
    enable = 1'b1;
    t0 = cyc;
    wait_until(t0 + PER + 4);
    n_cmp++;
    if (bus.dbo !== mq[0] || fifo_level !== 4'd1) begin
      n_bad++;
      $display("FAIL mr_pre got dbo=%h lvl=%0d want %h/1",
               bus.dbo, fifo_level, mq[0]);
    end
    #5;
    reset_n = 1'b0;
    enable = 1'b0;
    #1;
    n_cmp++;
    if ({bus.req, bus.wrt, bus.dbo, fifo_level} !== '0) begin
      n_bad++;
      $display("FAIL mr_clear got %h want 0",
               {bus.req, bus.wrt, bus.dbo, fifo_level});
    end
    @(negedge clk21m);
    reset_n = 1'b1;
    ack_mode = 0;
    obs.delete();
    repeat (60) @(negedge clk21m);
    n_cmp++;
    if (obs.size() !== 0) begin
      n_bad++;
      $display("FAIL mr_no_write got %0d want 0", obs.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_cfg();
    test_underrun();
    test_timeout();
    test_fill();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
